aes_decryption: RTL and testbench

AES-256 inverse cipher (FIPS-197 §5.3) on an AXI4-Stream-style 128-bit block interface. It is the receive-side counterpart of `aes_encryption`: it consumes ciphertext blocks and round keys from `key_expansion`, and emits plaintext blocks. The datapath is a fully unrolled, one-block-per-cycle pipeline with global stall on output backpressure, and `tlast` travels alongside each block.

---
 rtl/aes_decryption.sv | 153 +++++++++++++++
 tb/tb_aes_decryption.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decryption.sv
// AES-256 inverse cipher: fully unrolled 15-stage pipeline, one block per cycle,
// global stall when the output is held by downstream backpressure.
package aes_decryption_pkg;
    typedef logic [14:0][127:0] round_keys_t;
endpackage

module aes_decryption
    import aes_decryption_pkg::*;
#(
    parameter int ROUND_NUMBER = 14,
    parameter int TDATA_WIDTH  = 128
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [TDATA_WIDTH-1:0] aes_in_tdata,
    input  logic                   aes_in_tvalid,
    input  logic                   aes_in_tlast,
    output logic                   aes_in_tready,
    input  round_keys_t            round_keys,
    input  logic                   round_keys_valid,
    output logic [TDATA_WIDTH-1:0] aes_out_tdata,
    output logic                   aes_out_tvalid,
    output logic                   aes_out_tlast,
    input  logic                   aes_out_tready
);

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    // Entry 0 sits in the top byte, so byte b lives at bit (255-b)*8+7.
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[{~b, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        logic [7:0] res;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        case (k)
            4'h9:    res = x8 ^ a;
            4'hb:    res = x8 ^ x2 ^ a;
            4'hd:    res = x8 ^ x4 ^ a;
            4'he:    res = x8 ^ x4 ^ x2;
            default: res = 8'h00;
        endcase
        return res;
    endfunction

    // State byte i = row i%4, column i/4, stored at bits [127-8i -: 8].
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = 128'h0;
        for (int i = 0; i < 16; i++) begin
            o[127 - 8*i -: 8] = inv_sbox(s[127 - 8*i -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0;
        logic [7:0]   a1;
        logic [7:0]   a2;
        logic [7:0]   a3;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9);
            o[119 - 32*c -: 8] = gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd);
            o[111 - 32*c -: 8] = gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb);
            o[103 - 32*c -: 8] = gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he);
        end
        return o;
    endfunction

    logic [TDATA_WIDTH-1:0]  stage_data_r [0:ROUND_NUMBER];
    logic [ROUND_NUMBER:0]   stage_valid_r;
    logic [ROUND_NUMBER:0]   stage_last_r;
    logic [TDATA_WIDTH-1:0]  next_data_s  [1:ROUND_NUMBER];
    logic                    adv_s;
    logic                    accept_s;

    assign adv_s         = aes_out_tready || !aes_out_tvalid;
    assign aes_in_tready = adv_s && round_keys_valid;
    assign accept_s      = aes_in_tvalid && aes_in_tready;

    assign aes_out_tdata  = stage_data_r[ROUND_NUMBER];
    assign aes_out_tvalid = stage_valid_r[ROUND_NUMBER];
    assign aes_out_tlast  = stage_last_r[ROUND_NUMBER];

    // Stage r performs cipher round 14-r; the last stage skips InvMixColumns.
    for (genvar r = 1; r <= ROUND_NUMBER; r++) begin : g_round
        logic [TDATA_WIDTH-1:0] add_s;
        assign add_s = inv_sub_bytes(inv_shift_rows(stage_data_r[r-1])) ^ round_keys[ROUND_NUMBER-r];
        if (r < ROUND_NUMBER) begin : g_mix
            assign next_data_s[r] = inv_mix_columns(add_s);
        end else begin : g_final
            assign next_data_s[r] = add_s;
        end
    end

    // Pipeline registers: all stages shift together when adv_s, otherwise hold.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            stage_valid_r <= '0;
            stage_last_r  <= '0;
            for (int s = 0; s <= ROUND_NUMBER; s++) begin
                stage_data_r[s] <= '0;
            end
        end else if (adv_s) begin
            stage_data_r[0] <= aes_in_tdata ^ round_keys[ROUND_NUMBER];
            for (int s = 1; s <= ROUND_NUMBER; s++) begin
                stage_data_r[s] <= next_data_s[s];
            end
            stage_valid_r <= {stage_valid_r[ROUND_NUMBER-1:0], accept_s};
            stage_last_r  <= {stage_last_r[ROUND_NUMBER-1:0], accept_s && aes_in_tlast};
        end else begin
            stage_valid_r <= stage_valid_r;
            stage_last_r  <= stage_last_r;
        end
    end

endmodule

// File: tb/tb_aes_decryption.sv
// Directed bench for aes_decryption: FIPS-197 C.3, SP800-38A ECB-AES256, backpressure,
// keys-not-ready, mid-flight reset and an encrypt/decrypt round trip.
module tb_aes_decryption;
    import aes_decryption_pkg::*;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic         clk = 1'b0;
    logic         resetn;
    logic [127:0] aes_in_tdata;
    logic         aes_in_tvalid;
    logic         aes_in_tlast;
    logic         aes_in_tready;
    round_keys_t  round_keys;
    logic         round_keys_valid;
    logic [127:0] aes_out_tdata;
    logic         aes_out_tvalid;
    logic         aes_out_tlast;
    logic         aes_out_tready;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int stall_viol = 0;
    bit bp_mode = 1'b0;
    logic         stall_prev = 1'b0;
    logic [127:0] prev_data;
    logic         prev_last;

    logic [127:0] out_data_q [$];
    logic         out_last_q [$];
    int           out_cyc_q  [$];
    int           acc_cyc_q  [$];

    aes_decryption dut (
        .clk(clk), .resetn(resetn),
        .aes_in_tdata(aes_in_tdata), .aes_in_tvalid(aes_in_tvalid),
        .aes_in_tlast(aes_in_tlast), .aes_in_tready(aes_in_tready),
        .round_keys(round_keys), .round_keys_valid(round_keys_valid),
        .aes_out_tdata(aes_out_tdata), .aes_out_tvalid(aes_out_tvalid),
        .aes_out_tlast(aes_out_tlast), .aes_out_tready(aes_out_tready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Handshake monitor and output-hold checker, sampled mid-cycle.
    always @(negedge clk) begin
        if (resetn) begin
            if (aes_in_tvalid && aes_in_tready) acc_cyc_q.push_back(cyc);
            if (aes_out_tvalid && aes_out_tready) begin
                out_data_q.push_back(aes_out_tdata);
                out_last_q.push_back(aes_out_tlast);
                out_cyc_q.push_back(cyc);
            end
            if ((stall_prev && (!aes_out_tvalid || aes_out_tdata !== prev_data || aes_out_tlast !== prev_last)) ||
                (aes_out_tvalid && !aes_out_tready && aes_in_tready))
                stall_viol <= stall_viol + 1;
            stall_prev <= aes_out_tvalid && !aes_out_tready;
            prev_data  <= aes_out_tdata;
            prev_last  <= aes_out_tlast;
        end else begin
            stall_prev <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        logic [31:0] o;
        for (int i = 0; i < 4; i++) o[31 - 8*i -: 8] = SBOX[{~w[31 - 8*i -: 8], 3'b111} -: 8];
        return o;
    endfunction

    function automatic round_keys_t key_expand(input logic [255:0] key);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rcon;
        round_keys_t rk;
        for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
        rcon = 8'h01;
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end else if (i % 8 == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int k = 0; k < 15; k++) rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
        return rk;
    endfunction

    // Forward cipher reference, used only to produce round-trip ciphertexts.
    function automatic logic [127:0] encrypt(input logic [127:0] pt, input round_keys_t rk);
        logic [127:0] s;
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        s = pt ^ rk[0];
        for (int r = 1; r <= 14; r++) begin
            for (int i = 0; i < 4; i++) s[127 - 32*i -: 32] = sub_word(s[127 - 32*i -: 32]);
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++)
                    o[127 - 8*(4*c + q) -: 8] = s[127 - 8*(4*((c + q) % 4) + q) -: 8];
            s = o;
            if (r < 14) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[127 - 32*c -: 8]; a1 = s[119 - 32*c -: 8];
                    a2 = s[111 - 32*c -: 8]; a3 = s[103 - 32*c -: 8];
                    o[127 - 32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    o[119 - 32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    o[111 - 32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    o[103 - 32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
                s = o;
            end
            s = s ^ rk[r];
        end
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (bp_mode) aes_out_tready = 1'($urandom_range(0, 1));
        #1;
    endtask

    task automatic send(input logic [127:0] d, input logic l);
        bit acc;
        acc = 1'b0;
        aes_in_tdata  = d;
        aes_in_tlast  = l;
        aes_in_tvalid = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            #1;
            acc = aes_in_tready;
            tick();
        end
        if (!acc) check("send_timeout", 128'(acc), 128'd1);
        aes_in_tvalid = 1'b0;
    endtask

    task automatic wait_outputs(input string tag, input int n);
        for (int i = 0; i < 400 && out_data_q.size() < n; i++) tick();
        check(tag, 128'(out_data_q.size()), 128'(n));
    endtask

    task automatic clear_q();
        out_data_q.delete(); out_last_q.delete(); out_cyc_q.delete(); acc_cyc_q.delete();
    endtask

    logic [127:0] sp_ct [4] = '{128'hF3EED1BDB5D2A03C064B5A7E3DB181F8, 128'h591CCB10D410ED26DC5BA74A31362870,
                                128'hB6ED21B99CA6F4F9F153E7B1BEAFED1D, 128'h23304B7A39F9F3FF067D8D8F9E24ECC7};
    logic [127:0] sp_pt [4] = '{128'h6BC1BEE22E409F96E93D7E117393172A, 128'hAE2D8A571E03AC9C9EB76FAC45AF8E51,
                                128'h30C81C46A35CE411E5FBC1191A0A52EF, 128'hF69F2445DF4F9B17AD2B417BE66C3710};
    logic [127:0] rt_pt [8];
    logic         rt_last [8];
    round_keys_t  rk_sp;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0; round_keys_valid = 1'b0; round_keys = '0;
        aes_in_tdata = '0; aes_in_tvalid = 1'b0; aes_in_tlast = 1'b0; aes_out_tready = 1'b1;
        repeat (3) tick();
        check("rst_tvalid", 128'(aes_out_tvalid), 128'd0);
        check("rst_tlast",  128'(aes_out_tlast),  128'd0);
        check("rst_tdata",  aes_out_tdata,        128'd0);
        check("rst_tready", 128'(aes_in_tready),  128'd0);

        // FIPS-197 C.3
        resetn = 1'b1;
        round_keys = key_expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
        round_keys_valid = 1'b1;
        #1;
        check("keys_tready", 128'(aes_in_tready), 128'd1);
        clear_q();
        send(128'h8EA2B7CA516745BFEAFC49904B496089, 1'b1);
        wait_outputs("c3_count", 1);
        check("c3_data", out_data_q[0], 128'h00112233445566778899AABBCCDDEEFF);
        check("c3_last", 128'(out_last_q[0]), 128'd1);
        check("c3_latency", 128'(out_cyc_q[0] - acc_cyc_q[0]), 128'd15);

        // SP800-38A ECB-AES256, back-to-back
        rk_sp = key_expand(256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4);
        round_keys = rk_sp;
        clear_q();
        for (int i = 0; i < 4; i++) send(sp_ct[i], i == 3);
        wait_outputs("sp_count", 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("sp_data%0d", i), out_data_q[i], sp_pt[i]);
            check($sformatf("sp_last%0d", i), 128'(out_last_q[i]), 128'(i == 3));
            check($sformatf("sp_lat%0d", i), 128'(out_cyc_q[i] - acc_cyc_q[i]), 128'd15);
            if (i > 0) check($sformatf("sp_gap%0d", i), 128'(out_cyc_q[i] - out_cyc_q[i-1]), 128'd1);
        end

        // Backpressure with a one-cycle input gap
        clear_q();
        bp_mode = 1'b1;
        send(sp_ct[0], 1'b0);
        send(sp_ct[1], 1'b0);
        tick();
        send(sp_ct[2], 1'b0);
        send(sp_ct[3], 1'b1);
        wait_outputs("bp_count", 4);
        bp_mode = 1'b0;
        aes_out_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bp_data%0d", i), out_data_q[i], sp_pt[i]);
            check($sformatf("bp_last%0d", i), 128'(out_last_q[i]), 128'(i == 3));
        end

        // Keys not ready: input held off until keys become valid
        repeat (20) tick();
        clear_q();
        round_keys_valid = 1'b0;
        aes_in_tdata = sp_ct[1]; aes_in_tlast = 1'b1; aes_in_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("knr_tready%0d", i), 128'(aes_in_tready), 128'd0);
            repeat (5) tick();
        end
        check("knr_no_out", 128'(out_data_q.size()), 128'd0);
        round_keys_valid = 1'b1;
        send(sp_ct[1], 1'b1);
        wait_outputs("knr_count", 1);
        check("knr_data", out_data_q[0], sp_pt[1]);
        check("knr_last", 128'(out_last_q[0]), 128'd1);
        check("knr_latency", 128'(out_cyc_q[0] - acc_cyc_q[0]), 128'd15);

        // Reset with three blocks stalled at the pipe output
        clear_q();
        aes_out_tready = 1'b0;
        for (int i = 0; i < 3; i++) send(sp_ct[i], 1'b1);
        repeat (20) tick();
        check("rmf_stalled", 128'(aes_out_tvalid), 128'd1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check("rmf_tvalid", 128'(aes_out_tvalid), 128'd0);
        check("rmf_tlast",  128'(aes_out_tlast),  128'd0);
        check("rmf_tdata",  aes_out_tdata,        128'd0);
        aes_out_tready = 1'b1;
        repeat (30) tick();
        check("rmf_no_out", 128'(out_data_q.size()), 128'd0);

        // Round trip from the forward-cipher reference
        clear_q();
        for (int i = 0; i < 8; i++) begin
            rt_pt[i]   = {$urandom, $urandom, $urandom, $urandom};
            rt_last[i] = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < 8; i++) send(encrypt(rt_pt[i], rk_sp), rt_last[i]);
        wait_outputs("rt_count", 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("rt_data%0d", i), out_data_q[i], rt_pt[i]);
            check($sformatf("rt_last%0d", i), 128'(out_last_q[i]), 128'(rt_last[i]));
        end

        check("stall_hold", 128'(stall_viol), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
